// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: length/payload/checksum byte stream into instruction memory
module program_loader #(
    parameter logic [7:0]  BASE_ADDR = 8'd0,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       error,
    output logic [7:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_len;
    logic [7:0]  r_sum;
    logic [7:0]  r_count;
    logic [31:0] r_tmo;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [7:0]  r_mem_wdata;

    logic w_busy;
    logic w_xfer;
    logic w_start_ok;
    logic w_tmo_hit;
    logic w_last_data;

    assign w_busy      = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHECK);
    assign w_xfer      = in_valid && w_busy;
    assign w_start_ok  = start && !w_busy;
    // The idle cycle that brings the counter up to TIMEOUT is the one that aborts.
    assign w_tmo_hit   = w_busy && !w_xfer && (r_tmo == TMO_LAST);
    // count doubles as the payload index; N=0 wraps so the last index is 255.
    assign w_last_data = (r_count == (r_len - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    w_next = S_DATA;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_xfer && w_last_data) begin
                    w_next = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_CHECK: begin
                if (w_xfer) begin
                    w_next = (in_data == r_sum) ? S_DONE : S_ERR;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= 8'd0;
            r_sum       <= 8'd0;
            r_count     <= 8'd0;
            r_tmo       <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok) begin
                r_sum   <= 8'd0;
                r_count <= 8'd0;
                r_tmo   <= 32'd0;
            end else if (w_busy) begin
                r_tmo <= w_xfer ? 32'd0 : r_tmo + 32'd1;
            end
            if (w_xfer && (r_state == S_LEN)) begin
                r_len <= in_data;
            end
            if (w_xfer && (r_state == S_DATA)) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= BASE_ADDR + r_count;
                r_mem_wdata <= in_data;
                r_sum       <= r_sum + in_data;
                r_count     <= r_count + 8'd1;
            end
        end
    end

    assign in_ready  = w_busy;
    assign cpu_hold  = w_busy || (r_state == S_ERR);
    assign done      = (r_state == S_DONE);
    assign error     = (r_state == S_ERR);
    assign count     = r_count;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader (two base-address instances)
module tb_program_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid;
    logic [7:0] in_data;

    logic       a_in_ready, a_mem_we, a_cpu_hold, a_done, a_error;
    logic [7:0] a_mem_addr, a_mem_wdata, a_count;
    logic       b_in_ready, b_mem_we, b_cpu_hold, b_done, b_error;
    logic [7:0] b_mem_addr, b_mem_wdata, b_count;

    localparam logic [7:0] BASE_B = 8'd250;

    program_loader #(.BASE_ADDR(8'd0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .cpu_hold(a_cpu_hold), .done(a_done),
        .error(a_error), .count(a_count)
    );

    program_loader #(.BASE_ADDR(BASE_B), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .cpu_hold(b_cpu_hold), .done(b_done),
        .error(b_error), .count(b_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] payload[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic rdy, input logic hold,
                              input logic dn, input logic er, input logic [7:0] cnt);
        chk({tag, ".a.in_ready"}, 32'(a_in_ready), 32'(rdy));
        chk({tag, ".a.cpu_hold"}, 32'(a_cpu_hold), 32'(hold));
        chk({tag, ".a.done"},     32'(a_done),     32'(dn));
        chk({tag, ".a.error"},    32'(a_error),    32'(er));
        chk({tag, ".a.count"},    32'(a_count),    32'(cnt));
        chk({tag, ".b.in_ready"}, 32'(b_in_ready), 32'(rdy));
        chk({tag, ".b.cpu_hold"}, 32'(b_cpu_hold), 32'(hold));
        chk({tag, ".b.done"},     32'(b_done),     32'(dn));
        chk({tag, ".b.error"},    32'(b_error),    32'(er));
        chk({tag, ".b.count"},    32'(b_count),    32'(cnt));
    endtask

    task automatic chk_no_write(input string tag);
        chk({tag, ".a.mem_we"}, 32'(a_mem_we), 32'd0);
        chk({tag, ".b.mem_we"}, 32'(b_mem_we), 32'd0);
    endtask

    // One byte offered for one cycle; a payload byte must show up as a write right after.
    task automatic send(input logic [7:0] b, input bit wr, input logic [7:0] k);
        logic [7:0] addr_b;
        addr_b = BASE_B + k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        chk("send.a.in_ready", 32'(a_in_ready), 32'd1);
        chk("send.b.in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (wr) begin
            chk("wr.a.mem_we",    32'(a_mem_we),    32'd1);
            chk("wr.a.mem_addr",  32'(a_mem_addr),  32'(k));
            chk("wr.a.mem_wdata", 32'(a_mem_wdata), 32'(b));
            chk("wr.b.mem_we",    32'(b_mem_we),    32'd1);
            chk("wr.b.mem_addr",  32'(b_mem_addr),  32'(addr_b));
            chk("wr.b.mem_wdata", 32'(b_mem_wdata), 32'(b));
        end else begin
            chk_no_write("ctl");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk_no_write("idle");
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [7:0] payload_sum();
        logic [7:0] s;
        s = 8'd0;
        foreach (payload[i]) s = s + payload[i];
        return s;
    endfunction

    // Reference outcome: done iff the checksum byte equals the byte sum mod 256.
    task automatic run_load(input string tag, input logic [7:0] n, input logic [7:0] ck,
                            input int max_gap);
        logic       ok;
        logic [7:0] last_k, last_b;
        pulse_start();
        chk_status({tag, ".start"}, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        idle($urandom_range(0, max_gap));
        send(n, 1'b0, 8'd0);
        for (int k = 0; k < payload.size(); k++) begin
            idle($urandom_range(0, max_gap));
            send(payload[k], 1'b1, 8'(k));
        end
        idle($urandom_range(0, max_gap));
        send(ck, 1'b0, 8'd0);
        ok = (ck == payload_sum());
        chk_status({tag, ".end"}, 1'b0, !ok, ok, !ok, 8'(payload.size()));
        last_k = 8'(payload.size() - 1);
        last_b = BASE_B + last_k;
        idle(2);
        chk({tag, ".a.addr_hold"}, 32'(a_mem_addr), 32'(last_k));
        chk({tag, ".b.addr_hold"}, 32'(b_mem_addr), 32'(last_b));
    endtask

    task automatic fill_random(input int len);
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_no_write("reset");
        chk("reset.a.mem_addr", 32'(a_mem_addr), 32'd0);
        chk("reset.b.mem_wdata", 32'(b_mem_wdata), 32'd0);
        rst = 1'b0;
        idle(2);
        chk_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        payload = '{8'hB0, 8'hB5, 8'hBA};
        run_load("good3", 8'd3, 8'h1F, 0);
        chk("good3.a.done", 32'(a_done), 32'd1);

        run_load("bad3", 8'd3, 8'h20, 0);
        chk("bad3.a.error", 32'(a_error), 32'd1);

        payload.delete();
        for (int i = 0; i < 256; i++) payload.push_back(8'h01);
        run_load("n0", 8'd0, 8'h00, 0);
        chk("n0.a.done", 32'(a_done), 32'd1);

        fill_random(10);
        run_load("n10", 8'd10, payload_sum(), 2);
        chk("n10.b.done", 32'(b_done), 32'd1);

        for (int t = 0; t < 6; t++) begin
            int         len;
            logic [7:0] ck;
            len = $urandom_range(1, 40);
            fill_random(len);
            ck = ($urandom_range(0, 1) == 1) ? payload_sum() : 8'($urandom);
            run_load("rand", 8'(len), ck, 7);
        end

        // Stall after the second payload byte: 7 idle cycles survive, the 8th aborts.
        pulse_start();
        send(8'd5, 1'b0, 8'd0);
        send(8'h5A, 1'b1, 8'd0);
        send(8'hA5, 1'b1, 8'd1);
        idle(7);
        chk_status("stall7", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        idle(1);
        chk_status("stall8", 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
            chk_no_write("after_tmo");
        end
        in_valid = 1'b0;
        chk_status("after_tmo", 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);

        // start during DATA is ignored; reset mid-transfer drops the pending write.
        pulse_start();
        send(8'd4, 1'b0, 8'd0);
        send(8'h11, 1'b1, 8'd0);
        pulse_start();
        chk_status("start_in_data", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        send(8'h22, 1'b1, 8'd1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk_no_write("mid_rst");
        chk("mid_rst.a.mem_addr", 32'(a_mem_addr), 32'd0);
        chk("mid_rst.a.mem_wdata", 32'(a_mem_wdata), 32'd0);
        chk("mid_rst.b.mem_addr", 32'(b_mem_addr), 32'd0);
        idle(3);
        chk_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        fill_random(4);
        run_load("after_rst", 8'd4, payload_sum(), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0, is the 8-bit instruction-memory address where the first loaded instruction is written.
REQ-002 Parameter TIMEOUT, default 1000, is the number of consecutive idle cycles allowed between accepted bytes before the load aborts.
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_valid  input  1  byte-stream source has a valid byte on in_data.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  instruction-memory write enable.
REQ-010 mem_addr  output  8  instruction-memory write address.
REQ-011 mem_wdata  output  8  instruction-memory write data.
REQ-012 cpu_hold  output  1  holds the processor in reset while loading or after a failed load.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 error  output  1  last load failed on checksum mismatch or timeout.
REQ-015 count  output  8  number of instruction bytes written in the current or last load, modulo 256.

Function
REQ-016 A byte transfer SHALL occur only in a cycle where in_valid and in_ready are both 1.
REQ-017 The stream format SHALL be: one length byte N, then the instruction bytes, then one checksum byte.
REQ-018 The number of instruction bytes SHALL be N, except that N=0 SHALL mean 256 bytes.
REQ-019 The FSM states SHALL be IDLE, LEN, DATA, CHECK, DONE and ERR.
REQ-020 In IDLE, DONE or ERR, start=1 SHALL move the FSM to LEN and clear done, error, count, the checksum accumulator and the timeout counter.
REQ-021 start SHALL be ignored while in LEN, DATA or CHECK.
REQ-022 in_ready SHALL be 1 exactly in LEN, DATA and CHECK, which allows one transfer per cycle back-to-back.
REQ-023 A transfer in LEN SHALL latch N and move the FSM to DATA.
REQ-024 The k-th DATA transfer (k from 0) SHALL produce, in the next cycle, mem_we=1, mem_addr=(BASE_ADDR+k) mod 256 and mem_wdata equal to the byte, giving one cycle of write latency.
REQ-025 Each DATA transfer SHALL add the byte to an 8-bit checksum modulo 256 and increment count, with count wrapping from 255 to 0.
REQ-026 After the final DATA transfer, the FSM SHALL move to CHECK.
REQ-027 A transfer in CHECK SHALL move the FSM to DONE if the byte equals the accumulated checksum, otherwise to ERR.
REQ-028 mem_we SHALL be 0 in every cycle not covered by REQ-024, and mem_addr and mem_wdata SHALL hold their last values when mem_we is 0.
REQ-029 In LEN, DATA or CHECK, each cycle without a transfer SHALL increment the timeout counter, and each transfer SHALL reset it to 0.
REQ-030 When the timeout counter reaches TIMEOUT, the FSM SHALL move to ERR without performing further writes.
REQ-031 cpu_hold SHALL be 1 in LEN, DATA, CHECK and ERR, and 0 in IDLE and DONE.
REQ-032 done SHALL be 1 only in DONE, and error SHALL be 1 only in ERR, each asserting the cycle after the checksum transfer or timeout.
REQ-033 A write to the last address SHALL wrap: with BASE_ADDR=250 and N=10, addresses SHALL run 250..255 and then 0..3.

Reset
REQ-034 While rst=1, at the clock edge the FSM SHALL enter IDLE and set in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0 and count=0.
REQ-035 rst SHALL override every other input, including during an active load; a write pending from the reset cycle SHALL NOT occur, and the loader SHALL remain idle until the next start.

Verification
REQ-036 Bench: start, then bytes 03, B0, B5, BA, 1F continuous -> writes B0@0, B5@1, BA@2, each one cycle after acceptance; done=1; cpu_hold=0; count=3.
REQ-037 Bench: the same stream with checksum 20 -> error=1, done=0, cpu_hold=1, the three writes still performed.
REQ-038 Bench: N=00, 256 bytes of value 01, checksum 00 -> 256 writes at addresses 0..255, count=0, done=1.
REQ-039 Bench: BASE_ADDR=250, N=10 -> mem_addr runs 250..255, 0..3; with a correct checksum, done=1.
REQ-040 Bench: TIMEOUT=8, stall in_valid for 8 cycles after the second DATA byte -> error=1 and no further mem_we.
REQ-041 Bench: rst pulse mid-DATA, then start pulses in DATA and in IDLE -> after reset all outputs are 0; start in IDLE enters LEN; start in DATA is ignored.
